imem_load_ctrl: RTL and testbench
=================================

# imem_load_ctrl

Sequencing controller for the instruction fetch stage. It owns instruction-memory initialisation and CPU run control:
- assembles a byte stream from the debug/UART side into 32-bit words and writes them to instruction memory;
- then gates the pipeline through `o_cpu_halt` in continuous-run or single-step mode until the CPU reports a halt.

It sits between the debug unit's byte/command interface and the fetch stage's write-enable, write-data and halt inputs.

## Interface
Parameters:
- `NB_DATA`, 32, instruction word width; must equal 4 bytes.
- `NB_ADDR`, 8, instruction-memory word-address width (depth 2^NB_ADDR).
- `HALT_INSTR`, 32'hFFFF_FFFF, word that terminates a load and marks program end.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_rx_data` in 8: program byte.
- `i_rx_valid` in 1: byte valid; a byte transfers when `i_rx_valid && o_rx_ready`.
- `o_rx_ready` out 1: controller accepts bytes.
- `i_cmd` in 2: command; 0 = LOAD, 1 = RUN, 2 = STEP, 3 = reserved and ignored.
- `i_cmd_valid` in 1: single-cycle command strobe.
- `i_cpu_halted` in 1: CPU has retired `HALT_INSTR`.
- `o_imem_we` out 1: instruction-memory write enable.
- `o_imem_addr` out NB_ADDR: write word address.
- `o_imem_data` out NB_DATA: write data.
- `o_cpu_halt` out 1: freezes fetch/PC when high.
- `o_cpu_rst` out 1: one-cycle pipeline/PC restart pulse.
- `o_load_done` out 1: one-cycle pulse at load end.
- `o_word_count` out NB_ADDR+1: words written by the last load.
- `o_state` out 3: current FSM state, for debug readout.

## Operation
States: IDLE, LOAD, RUN, STEP, DONE.

Reset values (all outputs registered):
- FSM state IDLE; `o_cpu_halt` = 1.
- All other outputs 0; internal byte index 0.

State behaviour:
- **IDLE**
  - LOAD: go to LOAD; clear address, byte index and `o_word_count`.
  - RUN: go to RUN.
  - STEP: go to STEP.
- **LOAD**
  - `o_rx_ready` = 1.
  - Bytes are little-endian: 1st byte → [7:0], 4th byte → [31:24].
  - On the 4th byte, `o_imem_data` is loaded with the assembled word and `o_imem_we` pulses for exactly 1 cycle at the current `o_imem_addr`.
  - In the cycle after the pulse: `o_imem_addr` += 1 and `o_word_count` += 1.
  - Byte acceptance continues during the write cycle.
- **LOAD exit**
  - Triggered when the written word equals `HALT_INSTR`, or when the written address is 2^NB_ADDR−1 (memory full).
  - No wrap-around write is ever issued.
  - On exit: `o_rx_ready` drops in the write cycle; `o_load_done` and `o_cpu_rst` pulse together in the following cycle; state returns to IDLE.
- **RUN**
  - `o_cpu_halt` = 0 until `i_cpu_halted` = 1.
  - Then `o_cpu_halt` = 1 in the next cycle and state goes to DONE.
- **STEP**
  - `o_cpu_halt` = 0 for exactly one cycle, then state returns to IDLE, or goes to DONE if `i_cpu_halted` is seen in that cycle.
- **DONE**
  - `o_cpu_halt` = 1. LOAD is accepted; RUN and STEP are ignored.

Command and event rules:
- Commands are ignored in LOAD, RUN and STEP.
- Reserved command 3 is ignored everywhere.
- `i_cmd_valid` together with a simultaneous byte in IDLE: the byte is dropped, because `o_rx_ready` = 0 in IDLE.
- `i_cpu_halted` outside RUN/STEP is ignored.

## Timing
- Write latency: `o_imem_we` is asserted 1 cycle after the accepting edge of the 4th byte.
- Minimum of 4 accepted bytes per write; back-to-back bytes give one write every 4 cycles.
- RUN halt latency: `o_cpu_halt` rises 1 cycle after `i_cpu_halted`.
- Command latency: state changes on the edge that samples `i_cmd_valid`; its outputs take effect in the following cycle.
- Reset mid-operation (asynchronous) clears all state immediately:
  - partial words are discarded;
  - a pending write is cancelled;
  - `o_cpu_halt` is forced to 1.

## Structure
- Shared package `mips_dbg_pkg`:
  - state encoding: IDLE = 0, LOAD = 1, RUN = 2, STEP = 3, DONE = 4;
  - command codes: CMD_LOAD = 0, CMD_RUN = 1, CMD_STEP = 2;
  - `HALT_INSTR` default.
- One natural sub-module, `byte_to_word_packer`: 2-bit byte index plus 24-bit holding register, emitting a word-valid strobe. The FSM and address/count logic stay in the top.

## Test plan
- **Reset:** assert `i_rst` mid-cycle → outputs immediately at reset values, `o_cpu_halt` = 1, `o_state` = 0.
- **Load with halt word:** LOAD, then bytes 78 56 34 12 EF BE AD DE FF FF FF FF. Required response:
  - writes 0x12345678 @0, 0xDEADBEEF @1, 0xFFFFFFFF @2;
  - one `o_load_done`/`o_cpu_rst` pulse;
  - `o_word_count` = 3; return to IDLE.
- **Stalled byte stream:** `i_rx_valid` toggled randomly during LOAD → identical memory contents; no write before a 4th byte.
- **Memory full:** with NB_ADDR = 2, send 4 non-halt words → 4 writes at addresses 0..3, no 5th write, `o_load_done` pulses; later bytes are not accepted.
- **RUN to completion:** RUN, `i_cpu_halted` raised after 10 cycles → `o_cpu_halt` low for 10 cycles, high on cycle 11, state DONE; a subsequent RUN is ignored.
- **STEP ×3, then RUN mid-load:** `o_cpu_halt` low for exactly 1 cycle per step. A RUN issued during LOAD is ignored and the load completes normally.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the debug-side instruction-memory loader and run control.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/byte_to_word_packer.sv
// Little-endian byte-to-word assembler: three bytes are held, the fourth byte
// completes the word combinationally together with a one-cycle word strobe.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [23:0] hold_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= 2'd0;
            hold_q <= 24'd0;
        end else if (clear_i) begin
            idx_q  <= 2'd0;
            hold_q <= 24'd0;
        end else if (byte_valid_i) begin
            case (idx_q)
                2'd0:    hold_q[7:0]   <= byte_i;
                2'd1:    hold_q[15:8]  <= byte_i;
                2'd2:    hold_q[23:16] <= byte_i;
                default: hold_q        <= hold_q;
            endcase
            idx_q <= idx_q + 2'd1;
        end
    end

    assign word_valid_o = byte_valid_i && (idx_q == 2'd3) && !clear_i;
    assign word_o       = {byte_i, hold_q};

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load sequencer and CPU run/step gate for the fetch stage.
// All outputs are registers; next values are formed in one combinational process.
module imem_load_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int                NB_DATA    = 32,
    parameter int                NB_ADDR    = 8,
    parameter logic [NB_DATA-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    input  logic [1:0]         i_cmd,
    input  logic               i_cmd_valid,
    input  logic               i_cpu_halted,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0] o_imem_data,
    output logic               o_cpu_halt,
    output logic               o_cpu_rst,
    output logic               o_load_done,
    output logic [NB_ADDR:0]   o_word_count,
    output logic [2:0]         o_state
);

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_ADDR:0]   count_q, count_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               we_q, we_d;
    logic               rx_ready_q, rx_ready_d;
    logic               halt_q, halt_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               done_q, done_d;
    logic               last_q, last_d;

    logic               pack_clear;
    logic               word_valid;
    logic [31:0]        word;

    logic cmd_load, cmd_run, cmd_step;
    assign cmd_load = i_cmd_valid && (i_cmd == CMD_LOAD);
    assign cmd_run  = i_cmd_valid && (i_cmd == CMD_RUN);
    assign cmd_step = i_cmd_valid && (i_cmd == CMD_STEP);

    byte_to_word_packer u_packer (
        .clk          (clk),
        .rst_i        (i_rst),
        .clear_i      (pack_clear),
        .byte_valid_i (i_rx_valid && rx_ready_q),
        .byte_i       (i_rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        data_d     = data_q;
        we_d       = 1'b0;
        rx_ready_d = 1'b0;
        halt_d     = 1'b1;
        cpu_rst_d  = 1'b0;
        done_d     = 1'b0;
        last_d     = last_q;
        pack_clear = 1'b0;

        // Address and count advance in the cycle after each write pulse.
        if (we_q) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cmd_load) begin
                    state_d    = ST_LOAD;
                    addr_d     = '0;
                    count_d    = '0;
                    last_d     = 1'b0;
                    rx_ready_d = 1'b1;
                    pack_clear = 1'b1;
                end else if (cmd_run && state_q == ST_IDLE) begin
                    state_d = ST_RUN;
                    halt_d  = 1'b0;
                end else if (cmd_step && state_q == ST_IDLE) begin
                    state_d = ST_STEP;
                    halt_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (last_q) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                    last_d    = 1'b0;
                end else begin
                    rx_ready_d = 1'b1;
                    if (word_valid) begin
                        we_d   = 1'b1;
                        data_d = word;
                        // Halt word or top address ends the load; never wrap.
                        if (word == HALT_INSTR || addr_q == '1) begin
                            last_d     = 1'b1;
                            rx_ready_d = 1'b0;
                        end
                    end
                end
            end
            ST_RUN: begin
                halt_d = 1'b0;
                if (i_cpu_halted) begin
                    halt_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_STEP: begin
                state_d = i_cpu_halted ? ST_DONE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            rx_ready_q <= 1'b0;
            halt_q     <= 1'b1;
            cpu_rst_q  <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            we_q       <= we_d;
            rx_ready_q <= rx_ready_d;
            halt_q     <= halt_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            last_q     <= last_d;
        end
    end

    assign o_rx_ready   = rx_ready_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_data  = data_q;
    assign o_cpu_halt   = halt_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_load_done  = done_q;
    assign o_word_count = count_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl with a 4-word memory so the full-memory exit is reachable.
module tb_imem_load_ctrl;
    import mips_dbg_pkg::*;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 2;

    logic               clk = 1'b0;
    logic               i_rst;
    logic [7:0]         i_rx_data;
    logic               i_rx_valid;
    logic               o_rx_ready;
    logic [1:0]         i_cmd;
    logic               i_cmd_valid;
    logic               i_cpu_halted;
    logic               o_imem_we;
    logic [NB_ADDR-1:0] o_imem_addr;
    logic [NB_DATA-1:0] o_imem_data;
    logic               o_cpu_halt;
    logic               o_cpu_rst;
    logic               o_load_done;
    logic [NB_ADDR:0]   o_word_count;
    logic [2:0]         o_state;

    imem_load_ctrl #(
        .NB_DATA    (NB_DATA),
        .NB_ADDR    (NB_ADDR),
        .HALT_INSTR (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .i_cmd        (i_cmd),
        .i_cmd_valid  (i_cmd_valid),
        .i_cpu_halted (i_cpu_halted),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_cpu_halt   (o_cpu_halt),
        .o_cpu_rst    (o_cpu_rst),
        .o_load_done  (o_load_done),
        .o_word_count (o_word_count),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB_ADDR-1:0] addr;
        logic [31:0]        data;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    wr_t mon_w;
    int  compared    = 0;
    int  mismatched  = 0;
    int  writes_seen = 0;
    int  dones_seen  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [NB_ADDR-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic send_cmd(input logic [1:0] c);
        $display("cmd %0d at %0t", c, $time);
        i_cmd       = c;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int  n;
        bit  acc;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                i_rx_valid = 1'b0;
                i_rx_data  = 8'($urandom);
                tick();
            end
        end
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        n = 0;
        forever begin
            acc = o_rx_ready;
            tick();
            if (acc) break;
            n++;
            if (n > 50) begin
                check("byte_accept_timeout", 0, 1);
                break;
            end
        end
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], stall);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (dones_seen < target && n < 100) begin
            tick();
            n++;
        end
        check("load_done_seen", dones_seen, target);
        check("state_after_load", o_state, 3'd0);
        check("rx_ready_after_load", o_rx_ready, 1'b0);
        tick();
        check("load_done_single_pulse", o_load_done, 1'b0);
    endtask

    // Monitor: every write and every load-done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_imem_we) begin
                writes_seen++;
                if (wr_q.size() == 0) begin
                    check("unexpected_write_addr_data", {o_imem_addr, o_imem_data}, 64'hDEAD_0000_0000);
                end else begin
                    mon_w = wr_q.pop_front();
                    $display("write addr=%0h data=%08h", o_imem_addr, o_imem_data);
                    check("write_addr", o_imem_addr, mon_w.addr);
                    check("write_data", o_imem_data, mon_w.data);
                end
            end
            if (o_load_done) begin
                dones_seen++;
                $display("load_done word_count=%0d", o_word_count);
                if (done_q.size() == 0) check("unexpected_load_done", o_load_done, 1'b0);
                else check("word_count", o_word_count, done_q.pop_front());
                check("cpu_rst_with_done", o_cpu_rst, 1'b1);
            end else if (o_cpu_rst) begin
                check("stray_cpu_rst", o_cpu_rst, 1'b0);
            end
        end
    end

    int base;

    initial begin
        i_rst        = 1'b1;
        i_rx_data    = 8'h00;
        i_rx_valid   = 1'b0;
        i_cmd        = 2'd0;
        i_cmd_valid  = 1'b0;
        i_cpu_halted = 1'b0;

        // Reset values
        #12;
        check("rst_state", o_state, 3'd0);
        check("rst_halt", o_cpu_halt, 1'b1);
        check("rst_ready", o_rx_ready, 1'b0);
        check("rst_we", o_imem_we, 1'b0);
        check("rst_count", o_word_count, 0);
        @(posedge clk);
        #1 i_rst = 1'b0;
        tick();

        // Asynchronous reset out of RUN forces halt immediately
        send_cmd(CMD_RUN);
        check("run_halt_low", o_cpu_halt, 1'b0);
        #2 i_rst = 1'b1;
        #1;
        check("async_rst_halt", o_cpu_halt, 1'b1);
        check("async_rst_state", o_state, 3'd0);
        @(posedge clk);
        #1 i_rst = 1'b0;
        tick();

        // Asynchronous reset discards a partial word
        send_cmd(CMD_LOAD);
        check("load_ready", o_rx_ready, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        #2 i_rst = 1'b1;
        #1;
        check("async_rst_ready", o_rx_ready, 1'b0);
        check("async_rst_state2", o_state, 3'd0);
        @(posedge clk);
        #1 i_rst = 1'b0;
        tick();

        // Load terminated by the halt word
        expect_write(2'd0, 32'h1234_5678);
        expect_write(2'd1, 32'hDEAD_BEEF);
        expect_write(2'd2, 32'hFFFF_FFFF);
        done_q.push_back(3);
        send_cmd(CMD_LOAD);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        wait_done(1);

        // Reserved command and stray halted flag in IDLE are ignored
        send_cmd(CMD_RSVD);
        check("rsvd_ignored", o_state, 3'd0);
        i_cpu_halted = 1'b1;
        tick();
        i_cpu_halted = 1'b0;
        check("halted_in_idle_ignored", o_state, 3'd0);

        // Three single steps; the third sees the CPU halt
        for (int s = 0; s < 3; s++) begin
            send_cmd(CMD_STEP);
            check("step_halt_low", o_cpu_halt, 1'b0);
            check("step_state", o_state, 3'd3);
            if (s == 2) i_cpu_halted = 1'b1;
            tick();
            i_cpu_halted = 1'b0;
            check("step_halt_high", o_cpu_halt, 1'b1);
            check("step_exit_state", o_state, (s == 2) ? 3'd4 : 3'd0);
        end

        // Stalled stream from DONE with a RUN issued mid-load
        base = writes_seen;
        expect_write(2'd0, 32'h1234_5678);
        expect_write(2'd1, 32'hDEAD_BEEF);
        expect_write(2'd2, 32'hFFFF_FFFF);
        done_q.push_back(3);
        send_cmd(CMD_LOAD);
        check("load_from_done", o_state, 3'd1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (3) tick();
        check("no_write_before_4th_byte", writes_seen, base);
        send_byte(8'h12, 1'b1);
        send_cmd(CMD_RUN);
        check("run_ignored_in_load", o_state, 3'd1);
        send_word(32'hDEAD_BEEF, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        wait_done(2);

        // Memory full: four non-halt words fill addresses 0..3
        expect_write(2'd0, 32'hA1B2_C3D4);
        expect_write(2'd1, 32'h0000_0001);
        expect_write(2'd2, 32'h7FFF_FFFF);
        expect_write(2'd3, 32'hCAFE_F00D);
        done_q.push_back(4);
        send_cmd(CMD_LOAD);
        send_word(32'hA1B2_C3D4, 1'b0);
        send_word(32'h0000_0001, 1'b0);
        send_word(32'h7FFF_FFFF, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        wait_done(3);
        base = writes_seen;
        i_rx_data  = 8'h55;
        i_rx_valid = 1'b1;
        repeat (6) tick();
        i_rx_valid = 1'b0;
        check("no_accept_after_full", o_rx_ready, 1'b0);
        check("no_write_after_full", writes_seen, base);

        // RUN to completion: halted raised after 10 cycles
        send_cmd(CMD_RUN);
        for (int i = 0; i < 10; i++) begin
            check("run_halt_low_cycle", o_cpu_halt, 1'b0);
            if (i == 9) i_cpu_halted = 1'b1;
            tick();
        end
        i_cpu_halted = 1'b0;
        check("run_halt_rises", o_cpu_halt, 1'b1);
        check("run_to_done", o_state, 3'd4);
        send_cmd(CMD_RUN);
        tick();
        check("run_ignored_in_done", o_state, 3'd4);
        check("halt_held_in_done", o_cpu_halt, 1'b1);

        repeat (3) tick();
        check("scoreboard_writes_drained", wr_q.size(), 0);
        check("scoreboard_dones_drained", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
